// File: rtl/sdp_pkg.sv
// Shared definitions for the serial-link reply framer and its checksum helper.
package sdp_pkg;

  localparam logic [7:0] MARKER_SLAVE = 8'hA5;

  localparam int unsigned STAT_ERR     = 0;
  localparam int unsigned STAT_SREQ    = 1;
  localparam int unsigned STAT_BUSY    = 2;
  localparam int unsigned STAT_LEN_ERR = 3;
  localparam int unsigned STAT_DPS     = 4;
  localparam int unsigned STAT_CH_LSB  = 5;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CSUM    = 3'd3,
    S_END     = 3'd4
  } state_e;

endpackage

// File: rtl/sdp_csum8.sv
// 8-bit wrapping byte-sum accumulator; shared by the framer and the encoder-side checker.
module sdp_csum8 (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic [7:0] i_byte,
  output logic [7:0] o_sum
);

  logic [7:0] r_sum;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sum <= '0;
    end else if (i_clr) begin
      r_sum <= '0;
    end else if (i_en) begin
      r_sum <= r_sum + i_byte;
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/sdp_tx_framer.sv
// Slave-side reply framer: marker, status, N1, N2, optional channel payload, optional checksum.
module sdp_tx_framer
  import sdp_pkg::*;
#(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned LEN_W   = 11,
  parameter int unsigned MAX_LEN = 1024,
  parameter int unsigned CSUM_EN = 1,
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                s_req,
  input  logic                d_req,
  input  logic [CH_W-1:0]     req_ch,
  input  logic [LEN_W-1:0]    d_len,
  input  logic                rx_err,
  input  logic                sd_busy,
  input  logic                has_next_dp,
  input  logic [NUM_CH-1:0]   ch_tx_rdy,
  input  logic [8*NUM_CH-1:0] ch_d,
  input  logic [NUM_CH-1:0]   ch_vld,
  output logic [NUM_CH-1:0]   ch_rd,
  output logic [7:0]          q,
  output logic                q_vld,
  input  logic                q_rdy,
  output logic                active,
  output logic                msg_end
);

  state_e            r_state;
  state_e            w_next;
  state_e            w_tail;
  logic [1:0]        r_idx;
  logic [CH_W-1:0]   r_ch;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_cnt;
  logic [7:0]        r_status;

  logic              w_req;
  logic              w_len_err;
  logic [LEN_W-1:0]  w_len_cap;
  logic [NUM_CH-1:0] w_tx_rdy_sh;
  logic [7:0]        w_status;
  logic [15:0]       w_len16;
  logic [7:0]        w_src_byte;
  logic              w_src_vld;
  logic [NUM_CH-1:0] w_onehot;
  logic              w_xfer;
  logic              w_sum_en;
  logic              w_sum_clr;
  logic [7:0]        w_sum;

  assign w_req       = s_req | d_req;
  assign w_len_err   = d_req & ((d_len == '0) | (d_len > LEN_W'(MAX_LEN)));
  assign w_len_cap   = (d_req && !w_len_err) ? d_len : '0;
  assign w_tx_rdy_sh = ch_tx_rdy >> req_ch;
  assign w_len16     = 16'(r_len);
  assign w_onehot    = NUM_CH'(1) << r_ch;
  assign w_xfer      = q_vld & q_rdy;
  assign w_sum_clr   = (r_state == S_IDLE) & w_req;
  assign w_tail      = (CSUM_EN != 0) ? S_CSUM : S_END;

  // Status byte as seen at request time; frozen into r_status for the frame.
  always_comb begin
    w_status                          = '0;
    w_status[STAT_ERR]                = rx_err;
    w_status[STAT_SREQ]               = ~rx_err & ~sd_busy & (d_req ? has_next_dp : w_tx_rdy_sh[0]);
    w_status[STAT_BUSY]               = sd_busy;
    w_status[STAT_LEN_ERR]            = w_len_err;
    w_status[STAT_DPS]                = ~rx_err & d_req & ~w_len_err;
    w_status[7:STAT_CH_LSB]           = 3'(req_ch);
  end

  // Payload source mux; out-of-range channels read as never valid.
  always_comb begin
    w_src_byte = '0;
    w_src_vld  = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (r_ch == CH_W'(k)) begin
        w_src_byte = ch_d[8*k +: 8];
        w_src_vld  = ch_vld[k];
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    q        = '0;
    q_vld    = 1'b0;
    ch_rd    = '0;
    active   = (r_state != S_IDLE);
    msg_end  = 1'b0;
    w_sum_en = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) w_next = S_HDR;
      end
      S_HDR: begin
        q_vld = 1'b1;
        case (r_idx)
          2'd0:    q = MARKER_SLAVE;
          2'd1:    q = r_status;
          2'd2:    q = w_len16[15:8];
          default: q = w_len16[7:0];
        endcase
        if (q_rdy) begin
          w_sum_en = (r_idx != 2'd0);
          if (r_idx == 2'd3) w_next = (r_len != '0) ? S_PAYLOAD : w_tail;
        end
      end
      S_PAYLOAD: begin
        q_vld = w_src_vld;
        q     = w_src_vld ? w_src_byte : 8'd0;
        if (w_src_vld && q_rdy) begin
          ch_rd    = w_onehot;
          w_sum_en = 1'b1;
          if (r_cnt == LEN_W'(1)) w_next = w_tail;
        end
      end
      S_CSUM: begin
        q_vld = 1'b1;
        q     = w_sum;
        if (q_rdy) w_next = S_END;
      end
      S_END: begin
        msg_end = 1'b1;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Frame context, header index and payload down-counter.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_ch     <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_status <= '0;
      r_idx    <= '0;
    end else begin
      if (w_sum_clr) begin
        r_ch     <= req_ch;
        r_len    <= w_len_cap;
        r_cnt    <= w_len_cap;
        r_status <= w_status;
        r_idx    <= '0;
      end
      if ((r_state == S_HDR) && w_xfer) r_idx <= r_idx + 2'd1;
      if ((r_state == S_PAYLOAD) && w_xfer) r_cnt <= r_cnt - LEN_W'(1);
    end
  end

  sdp_csum8 u_csum (
    .clk    (clk),
    .n_rst  (n_rst),
    .i_clr  (w_sum_clr),
    .i_en   (w_sum_en),
    .i_byte (q),
    .o_sum  (w_sum)
  );

endmodule

// File: tb/tb_sdp_tx_framer.sv
// Scoreboard bench for sdp_tx_framer: requests push expected bytes, a negedge monitor pops and compares.
module tb_sdp_tx_framer;
  import sdp_pkg::*;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        s_req, d_req;
  logic [0:0]  req_ch;
  logic [10:0] d_len;
  logic        rx_err, sd_busy, has_next_dp;
  logic [1:0]  ch_tx_rdy;
  logic [15:0] ch_d;
  logic [1:0]  ch_vld;
  logic [1:0]  ch_rd;
  logic [7:0]  q;
  logic        q_vld, q_rdy, active, msg_end;

  logic [7:0] exp_q[$];
  logic [7:0] pay_q[$];
  int nvec = 0, nerr = 0;
  int src_ch = 0;
  bit rnd_mode = 1'b0, pop_src = 1'b0, end_due = 1'b0;
  int ends_seen = 0, ends_exp = 0, xfers = 0, rd_cnt = 0;
  int base;

  sdp_tx_framer dut (
    .clk(clk), .n_rst(n_rst), .s_req(s_req), .d_req(d_req), .req_ch(req_ch),
    .d_len(d_len), .rx_err(rx_err), .sd_busy(sd_busy), .has_next_dp(has_next_dp),
    .ch_tx_rdy(ch_tx_rdy), .ch_d(ch_d), .ch_vld(ch_vld), .ch_rd(ch_rd),
    .q(q), .q_vld(q_vld), .q_rdy(q_rdy), .active(active), .msg_end(msg_end)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_frame(input logic [7:0] st, input int n, input logic [7:0] cs);
    exp_q.push_back(MARKER_SLAVE);
    exp_q.push_back(st);
    exp_q.push_back(8'(n >> 8));
    exp_q.push_back(8'(n));
    foreach (pay_q[i]) exp_q.push_back(pay_q[i]);
    exp_q.push_back(cs);
    ends_exp++;
  endtask

  task automatic issue(input bit s, input bit d, input int ch, input int len,
                       input bit rxe, input bit busy, input bit nxt);
    @(posedge clk); #1;
    s_req = s; d_req = d; req_ch = 1'(ch); d_len = 11'(len);
    rx_err = rxe; sd_busy = busy; has_next_dp = nxt; src_ch = ch;
    @(posedge clk); #1;
    s_req = 1'b0; d_req = 1'b0; rx_err = 1'b0; sd_busy = 1'b0; has_next_dp = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int i = 0;
    while ((exp_q.size() != 0 || end_due) && i < 6000) begin
      @(negedge clk);
      i++;
    end
    check({name, "_done"}, 32'(exp_q.size() == 0 && !end_due), 1);
    check({name, "_ends"}, ends_seen, ends_exp);
    repeat (2) @(posedge clk);
  endtask

  // Source model and sink backpressure, updated just after each rising edge.
  initial forever begin
    @(posedge clk); #1;
    if (pop_src && pay_q.size() > 0) void'(pay_q.pop_front());
    pop_src = 1'b0;
    if (rnd_mode) q_rdy = ($urandom_range(0, 3) != 0);
    else          q_rdy = 1'b1;
    ch_d   = '0;
    ch_vld = '0;
    if (pay_q.size() > 0 && (!rnd_mode || $urandom_range(0, 3) != 0)) begin
      ch_d[8*src_ch +: 8] = pay_q[0];
      ch_vld[src_ch]      = 1'b1;
    end
  end

  // Monitor: compare presented bytes with the scoreboard head, track msg_end and ch_rd.
  always @(negedge clk) begin
    if (n_rst) begin
      if (end_due) begin
        check("msg_end_timing", msg_end, 1);
        if (msg_end) ends_seen++;
        end_due = 1'b0;
      end else if (msg_end) begin
        check("msg_end_spurious", msg_end, 0);
      end
      if (q_vld) begin
        if (exp_q.size() == 0) begin
          check("q_unexpected", q_vld, 0);
        end else begin
          check("q_byte", q, exp_q[0]);
          if (q_rdy) begin
            void'(exp_q.pop_front());
            xfers++;
            if (exp_q.size() == 0) end_due = 1'b1;
          end
        end
      end else begin
        check("q_zero_idle", q, 0);
      end
      if (ch_rd != '0) begin
        rd_cnt++;
        check("ch_rd_onehot", ch_rd, 32'(1) << src_ch);
        check("ch_rd_xfer", q_vld & q_rdy, 1);
        pop_src = 1'b1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst = 1'b0; s_req = 1'b0; d_req = 1'b0; req_ch = '0; d_len = '0;
    rx_err = 1'b0; sd_busy = 1'b0; has_next_dp = 1'b0; ch_tx_rdy = 2'b10;
    ch_d = '0; ch_vld = '0; q_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_q_vld", q_vld, 0);
    check("rst_q", q, 0);
    check("rst_active", active, 0);
    check("rst_msg_end", msg_end, 0);
    check("rst_ch_rd", ch_rd, 0);
    @(posedge clk); #2 n_rst = 1'b1;

    // Service frame on channel 1 with its tx-ready bit set
    expect_frame(8'h22, 0, 8'h22);
    issue(1, 0, 1, 0, 0, 0, 0);
    wait_done("svc");

    // Data frame, 3 bytes from channel 0
    pay_q = '{8'h01, 8'h02, 8'h03};
    rd_cnt = 0;
    expect_frame(8'h12, 3, 8'h1B);
    issue(0, 1, 0, 3, 0, 0, 1);
    wait_done("data3");
    check("data3_rd_cnt", rd_cnt, 3);

    // Max-length frame under random sink and source stalls
    for (int i = 0; i < 1024; i++) pay_q.push_back(8'(i));
    rd_cnt = 0;
    base = xfers;
    rnd_mode = 1'b1;
    expect_frame(8'h30, 1024, 8'h34);
    issue(0, 1, 1, 1024, 0, 0, 0);
    wait_done("bp");
    rnd_mode = 1'b0;
    check("bp_xfers", xfers - base, 1029);
    check("bp_rd_cnt", rd_cnt, 1024);

    // Length errors: zero and MAX_LEN+1
    rd_cnt = 0;
    expect_frame(8'h08, 0, 8'h08);
    issue(0, 1, 0, 0, 0, 0, 0);
    wait_done("len0");
    expect_frame(8'h08, 0, 8'h08);
    issue(0, 1, 0, 1025, 0, 0, 0);
    wait_done("len1025");
    check("lenerr_rd_cnt", rd_cnt, 0);

    // Simultaneous requests give a data frame; a request during HDR is ignored
    pay_q = '{8'hAA, 8'hBB};
    expect_frame(8'h10, 2, 8'h77);
    issue(1, 1, 0, 2, 0, 0, 0);
    s_req = 1'b1;
    @(posedge clk); #1 s_req = 1'b0;
    wait_done("collide");

    // rx_err at request clears the data bit
    pay_q = '{8'h05};
    expect_frame(8'h01, 1, 8'h07);
    issue(0, 1, 0, 1, 1, 0, 0);
    wait_done("rxerr");

    // Reset while payload byte 5 is on the bus
    for (int i = 0; i < 10; i++) pay_q.push_back(8'(8'h10 + i));
    expect_frame(8'h10, 10, 8'hE7);
    base = xfers;
    issue(0, 1, 0, 10, 0, 0, 0);
    for (int i = 0; i < 100 && xfers < base + 8; i++) @(posedge clk);
    #2;
    check("pre_rst_byte5", q, 8'h14);
    n_rst = 1'b0;
    #1;
    check("arst_q_vld", q_vld, 0);
    check("arst_active", active, 0);
    check("arst_ch_rd", ch_rd, 0);
    exp_q.delete();
    pay_q.delete();
    end_due = 1'b0;
    pop_src = 1'b0;
    ends_exp--;
    repeat (2) @(posedge clk);
    #2 n_rst = 1'b1;
    repeat (3) @(posedge clk);
    check("post_rst_no_msg_end", ends_seen, ends_exp);

    pay_q = '{8'h01, 8'h02, 8'h03};
    rd_cnt = 0;
    expect_frame(8'h12, 3, 8'h1B);
    issue(0, 1, 0, 3, 0, 0, 1);
    wait_done("post_rst");
    check("post_rst_rd_cnt", rd_cnt, 3);
    check("final_ends", ends_seen, ends_exp);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
